psram_async_responder: RTL and testbench
========================================

// Module: psram_async_responder
// PURPOSE
//  Synthesizable responder for the MT45W8MW16 async PSRAM pin interface: the device side of the RAM bus.
//  Decodes RamCEn/RamOEn/RamWEn/RamLBn/RamUBn/MemAdr and serves reads/writes from an internal word array.
//  Access times are programmable, so it stands in for the real part in FPGA loopback and RAM-controller benches.
// PARAMETERS
//  DEPTH_LOG2   10        array depth = 2**DEPTH_LOG2 16-bit words; only MemAdr[DEPTH_LOG2-1:0] decoded
//  READ_LAT     8         clk cycles from sampled read start to data driven (min 1)
//  WRITE_LAT    8         clk cycles WEn must stay low before the write commits (min 1)
//  INIT_VALUE   16'h0000  power-up content of every word (initial load, not reset)
// PORTS
//  clk         in     1   system clock; all sampling on rising edge
//  reset       in     1   synchronous, active-high
//  RamCLK      in     1   unused (async mode only)
//  RamADVn     in     1   unused (async mode: tied low by initiator)
//  RamCEn      in     1   chip enable, active low
//  RamCRE      in     1   config-register enable; access with CRE=1 is flagged, not served
//  RamOEn      in     1   output enable, active low
//  RamWEn      in     1   write enable, active low
//  RamLBn      in     1   lower byte lane enable, active low
//  RamUBn      in     1   upper byte lane enable, active low
//  MemAdr      in     23  word address
//  MemDB       inout  16  data bus; Z unless driving read data
//  RamWait     out    1   high while an access is in its latency window
//  protocol_err out   1   sticky: illegal pin combination seen
//  rd_count    out    16  completed reads (see CONFIGURATION)
//  wr_count    out    16  committed writes (see CONFIGURATION)
// BEHAVIOUR
//  - Control pins, MemAdr and MemDB sampled into one register stage; FSM acts on sampled values.
//  - Reset: state IDLE, counter 0, RamWait 0, protocol_err 0, counts 0, MemDB Z from next edge. Array NOT cleared.
//  - States: IDLE, RD_WAIT, RD_DRIVE, WR_WAIT, WR_HOLD.
//  - IDLE: CEn=0,OEn=0,WEn=1,CRE=0 -> RD_WAIT, latch addr, counter=READ_LAT-1.
//          CEn=0,WEn=0,CRE=0 -> WR_WAIT, latch addr, counter=WRITE_LAT-1 (WEn wins over OEn, flag err if OEn=0).
//  - RD_WAIT: counter--; CEn or OEn high -> IDLE (abort, no drive); counter==0 -> RD_DRIVE.
//  - RD_DRIVE: MemDB[7:0]=mem[addr][7:0] iff LBn=0, MemDB[15:8] iff UBn=0, gated combinationally with
//    raw RamCEn=0 & RamOEn=0 (bus releases same cycle initiator deasserts). Sampled addr change -> RD_WAIT,
//    new addr, counter reloaded. CEn or OEn high -> IDLE, rd_count++.
//  - WR_WAIT: counter--; CEn or WEn high before 0 -> IDLE, nothing written. counter==0: commit sampled MemDB
//    to mem[addr] per byte enable (LBn/UBn as sampled that cycle), wr_count++ -> WR_HOLD.
//  - WR_HOLD: wait CEn or WEn high -> IDLE; further data while held is ignored (one commit per WEn pulse).
//  - RamWait = 1 exactly in RD_WAIT/WR_WAIT, registered.
//  - protocol_err set on sampled CEn=0 with (OEn=0 & WEn=0) or CRE=1; clears only on reset.
//  - Address aliasing: upper MemAdr bits ignored; addr 0x000400 hits word 0 at DEPTH_LOG2=10.
//  - Both LBn/UBn high: read drives nothing, write commits nothing but still counts.
//  - Counters saturate at 16'hFFFF.
// CONFIGURATION
//  PSRAM_RESP_STATS_EN defined: rd_count/wr_count live as above.
//  Undefined: counters not built, rd_count/wr_count tied 16'h0000; all other behaviour identical.
// TESTING
//  - Write 16'hA5C3 to addr 0x000012 with WEn low 12 cycles, then read addr 0x12 -> MemDB=16'hA5C3 after READ_LAT+1 cycles.
//  - Write with WEn low only 5 cycles (WRITE_LAT=8) -> word unchanged, wr_count unchanged, RamWait falls on abort.
//  - Byte write 16'h1234 over 16'hFFFF with LBn=0,UBn=1 -> read returns 16'hFF34; read with UBn=1 -> MemDB[15:8]=Z.
//  - Pulse reset during RD_DRIVE -> MemDB Z next edge, RamWait 0, data at addr still readable afterwards.
//  - CEn=0,OEn=0,WEn=0 for 3 cycles -> protocol_err=1 and stays 1 until reset; CRE=1 access also sets it.
//  - Read addr 0x000400 after writing 16'hBEEF to 0x0 (DEPTH_LOG2=10) -> 16'hBEEF; with PSRAM_RESP_STATS_EN rd_count=1, wr_count=1.

Source files
------------

// File: rtl/psram_async_responder_if.sv
// Async PSRAM pin bundle (MT45W8MW16 style). MemDB is a tristate net and stays a
// plain port on the responder; everything else is grouped here.
interface psram_async_responder_if;
   logic        RamCLK;
   logic        RamADVn;
   logic        RamCEn;
   logic        RamCRE;
   logic        RamOEn;
   logic        RamWEn;
   logic        RamLBn;
   logic        RamUBn;
   logic [22:0] MemAdr;
   logic        RamWait;

   modport master (
      output RamCLK, RamADVn, RamCEn, RamCRE, RamOEn, RamWEn, RamLBn, RamUBn, MemAdr,
      input  RamWait
   );

   modport slave (
      input  RamCLK, RamADVn, RamCEn, RamCRE, RamOEn, RamWEn, RamLBn, RamUBn, MemAdr,
      output RamWait
   );
endinterface

// File: rtl/psram_async_responder.sv
// Device-side model of an async PSRAM with programmable read/write latency.
// Define PSRAM_RESP_STATS_EN to build the saturating read/write completion counters.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | no access in progress, bus released
// S_RD_WAIT  | read latency running, RamWait high
// S_RD_DRIVE | read data on MemDB while CEn/OEn stay low
// S_WR_WAIT  | write latency running, RamWait high
// S_WR_HOLD  | write committed, waiting for WEn/CEn to rise
module psram_async_responder #(
   parameter int          DEPTH_LOG2 = 10,
   parameter int          READ_LAT   = 8,
   parameter int          WRITE_LAT  = 8,
   parameter logic [15:0] INIT_VALUE = 16'h0000
) (
   input  logic                    clk,
   input  logic                    reset,
   psram_async_responder_if.slave  ram,
   inout  wire  [15:0]             MemDB,
   output logic                    protocol_err_o,
   output logic [15:0]             rd_count_o,
   output logic [15:0]             wr_count_o
);

   localparam int DEPTH   = 2 ** DEPTH_LOG2;
   localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
   localparam int CNT_W   = ($clog2(MAX_LAT) > 0) ? $clog2(MAX_LAT) : 1;
   localparam logic [CNT_W-1:0] R_LOAD = CNT_W'(READ_LAT - 1);
   localparam logic [CNT_W-1:0] W_LOAD = CNT_W'(WRITE_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_WAIT,
      S_RD_DRIVE,
      S_WR_WAIT,
      S_WR_HOLD
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0]  addr_q, addr_d;
   logic                   wait_q, wait_d;
   logic                   err_q, err_d;
   logic                   rd_done;
   logic                   wr_commit;

   logic                   cen_q, oen_q, wen_q, cre_q, lbn_q, ubn_q;
   logic [DEPTH_LOG2-1:0]  adr_q;
   logic [15:0]            db_q;

   // Power-up content only; reset deliberately leaves the array alone.
   logic [15:0]            mem [0:DEPTH-1] = '{default: INIT_VALUE};
   logic [15:0]            rd_word;
   logic                   bus_rd_en;

   logic                   unused_pins;
   assign unused_pins = ^{ram.RamCLK, ram.RamADVn, ram.MemAdr[22:DEPTH_LOG2]};

   always_ff @(posedge clk) begin
      if (reset) begin
         cen_q <= 1'b1;
         oen_q <= 1'b1;
         wen_q <= 1'b1;
         cre_q <= 1'b0;
         lbn_q <= 1'b1;
         ubn_q <= 1'b1;
         adr_q <= '0;
         db_q  <= '0;
      end else begin
         cen_q <= ram.RamCEn;
         oen_q <= ram.RamOEn;
         wen_q <= ram.RamWEn;
         cre_q <= ram.RamCRE;
         lbn_q <= ram.RamLBn;
         ubn_q <= ram.RamUBn;
         adr_q <= ram.MemAdr[DEPTH_LOG2-1:0];
         db_q  <= MemDB;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wait_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      rd_done   = 1'b0;
      wr_commit = 1'b0;
      case (state_q)
         S_IDLE: begin
            // WEn takes priority over OEn; the illegal combo is flagged below.
            if (!cen_q && !cre_q) begin
               if (!wen_q) begin
                  state_d = S_WR_WAIT;
                  addr_d  = adr_q;
                  cnt_d   = W_LOAD;
               end else if (!oen_q) begin
                  state_d = S_RD_WAIT;
                  addr_d  = adr_q;
                  cnt_d   = R_LOAD;
               end
            end
         end
         S_RD_WAIT: begin
            if (cen_q || oen_q) begin
               state_d = S_IDLE;
            end else if (cnt_q == '0) begin
               state_d = S_RD_DRIVE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RD_DRIVE: begin
            if (cen_q || oen_q) begin
               state_d = S_IDLE;
               rd_done = 1'b1;
            end else if (adr_q != addr_q) begin
               state_d = S_RD_WAIT;
               addr_d  = adr_q;
               cnt_d   = R_LOAD;
            end
         end
         S_WR_WAIT: begin
            if (cen_q || wen_q) begin
               state_d = S_IDLE;
            end else if (cnt_q == '0) begin
               state_d   = S_WR_HOLD;
               wr_commit = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_WR_HOLD: begin
            if (cen_q || wen_q) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      wait_d = (state_d == S_RD_WAIT) || (state_d == S_WR_WAIT);
      err_d  = err_q | (!cen_q && ((!oen_q && !wen_q) || cre_q));
   end

   always_ff @(posedge clk) begin
      if (wr_commit && !reset) begin
         if (!lbn_q) mem[addr_q][7:0]  <= db_q[7:0];
         if (!ubn_q) mem[addr_q][15:8] <= db_q[15:8];
      end
   end

   // Drive gating uses raw pins so the bus lets go in the cycle the initiator does.
   assign rd_word      = mem[addr_q];
   assign bus_rd_en    = (state_q == S_RD_DRIVE) && !ram.RamCEn && !ram.RamOEn;
   assign MemDB[7:0]   = (bus_rd_en && !ram.RamLBn) ? rd_word[7:0]  : 8'hzz;
   assign MemDB[15:8]  = (bus_rd_en && !ram.RamUBn) ? rd_word[15:8] : 8'hzz;

   assign ram.RamWait     = wait_q;
   assign protocol_err_o  = err_q;

`ifdef PSRAM_RESP_STATS_EN
   logic [15:0] rd_cnt_q;
   logic [15:0] wr_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         if (rd_done && (rd_cnt_q != 16'hFFFF)) rd_cnt_q <= rd_cnt_q + 16'd1;
         if (wr_commit && (wr_cnt_q != 16'hFFFF)) wr_cnt_q <= wr_cnt_q + 16'd1;
      end
   end

   assign rd_count_o = rd_cnt_q;
   assign wr_count_o = wr_cnt_q;
`else
   logic unused_rd_done;
   assign unused_rd_done = rd_done;
   assign rd_count_o     = 16'h0000;
   assign wr_count_o     = 16'h0000;
`endif

endmodule

// File: tb/tb_psram_async_responder.sv
// Directed bench for psram_async_responder at default parameters.
// MemDB carries pull-ups, so a released byte lane reads back as 8'hFF.
module tb_psram_async_responder;

`ifdef PSRAM_RESP_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        tb_oe;
   logic [15:0] tb_dq;
   wire  [15:0] mem_db;
   logic        protocol_err;
   logic [15:0] rd_count;
   logic [15:0] wr_count;
   int          n_tests = 0;
   int          n_fail  = 0;

   psram_async_responder_if ram_if ();

   psram_async_responder dut (
      .clk            (clk),
      .reset          (reset),
      .ram            (ram_if),
      .MemDB          (mem_db),
      .protocol_err_o (protocol_err),
      .rd_count_o     (rd_count),
      .wr_count_o     (wr_count)
   );

   assign mem_db = tb_oe ? tb_dq : 16'hzzzz;

   for (genvar g = 0; g < 16; g++) begin : g_pu
      pullup (mem_db[g]);
   end

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pins_idle();
      ram_if.RamCLK  = 1'b0;
      ram_if.RamADVn = 1'b0;
      ram_if.RamCEn  = 1'b1;
      ram_if.RamCRE  = 1'b0;
      ram_if.RamOEn  = 1'b1;
      ram_if.RamWEn  = 1'b1;
      ram_if.RamLBn  = 1'b0;
      ram_if.RamUBn  = 1'b0;
      tb_oe          = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      pins_idle();
      cyc(2);
      reset = 1'b0;
      cyc(1);
   endtask

   task automatic wr_word(input logic [22:0] addr, input logic [15:0] data,
                          input logic lbn, input logic ubn, input int ncyc);
      ram_if.MemAdr = addr;
      tb_dq         = data;
      tb_oe         = 1'b1;
      ram_if.RamLBn = lbn;
      ram_if.RamUBn = ubn;
      ram_if.RamOEn = 1'b1;
      ram_if.RamCEn = 1'b0;
      ram_if.RamWEn = 1'b0;
      cyc(ncyc);
      pins_idle();
      cyc(3);
   endtask

   task automatic rd_chk(input string tag, input logic [22:0] addr,
                         input logic lbn, input logic ubn, input logic [15:0] exp);
      ram_if.MemAdr = addr;
      ram_if.RamLBn = lbn;
      ram_if.RamUBn = ubn;
      ram_if.RamWEn = 1'b1;
      ram_if.RamCEn = 1'b0;
      ram_if.RamOEn = 1'b0;
      cyc(9);
      check({tag, "_wait_hi"}, {15'd0, ram_if.RamWait}, 16'd1);
      cyc(1);
      check({tag, "_data"}, mem_db, exp);
      check({tag, "_wait_lo"}, {15'd0, ram_if.RamWait}, 16'd0);
      ram_if.RamCEn = 1'b1;
      ram_if.RamOEn = 1'b1;
      #1;
      check({tag, "_release"}, mem_db, 16'hFFFF);
      pins_idle();
      cyc(3);
   endtask

   initial begin
      ram_if.MemAdr = '0;
      tb_dq         = '0;
      pins_idle();
      reset = 1'b1;
      cyc(3);
      check("rst_wait", {15'd0, ram_if.RamWait}, 16'd0);
      check("rst_err",  {15'd0, protocol_err}, 16'd0);
      check("rst_rdc",  rd_count, 16'd0);
      check("rst_wrc",  wr_count, 16'd0);
      check("rst_bus",  mem_db, 16'hFFFF);
      reset = 1'b0;
      cyc(2);

      wr_word(23'h000012, 16'hA5C3, 1'b0, 1'b0, 12);
      check("wr1_wrc", wr_count, STATS ? 16'd1 : 16'd0);
      rd_chk("rd1", 23'h000012, 1'b0, 1'b0, 16'hA5C3);
      check("rd1_rdc", rd_count, STATS ? 16'd1 : 16'd0);

      // Write aborted before WRITE_LAT elapses.
      ram_if.MemAdr = 23'h000012;
      tb_dq         = 16'h0000;
      tb_oe         = 1'b1;
      ram_if.RamCEn = 1'b0;
      ram_if.RamWEn = 1'b0;
      cyc(5);
      check("short_wait_hi", {15'd0, ram_if.RamWait}, 16'd1);
      pins_idle();
      cyc(3);
      check("short_wait_lo", {15'd0, ram_if.RamWait}, 16'd0);
      check("short_wrc", wr_count, STATS ? 16'd1 : 16'd0);
      rd_chk("rd_short", 23'h000012, 1'b0, 1'b0, 16'hA5C3);

      wr_word(23'h000020, 16'hFFFF, 1'b0, 1'b0, 12);
      wr_word(23'h000020, 16'h1234, 1'b0, 1'b1, 12);
      rd_chk("rd_byte", 23'h000020, 1'b0, 1'b0, 16'hFF34);
      rd_chk("rd_lo_only", 23'h000012, 1'b0, 1'b1, 16'hFFC3);
      check("byte_wrc", wr_count, STATS ? 16'd3 : 16'd0);
      check("byte_rdc", rd_count, STATS ? 16'd4 : 16'd0);

      // Reset asserted while data is on the bus.
      ram_if.MemAdr = 23'h000012;
      ram_if.RamCEn = 1'b0;
      ram_if.RamOEn = 1'b0;
      cyc(10);
      check("pre_rst_data", mem_db, 16'hA5C3);
      reset = 1'b1;
      cyc(1);
      check("rst_drv_bus",  mem_db, 16'hFFFF);
      check("rst_drv_wait", {15'd0, ram_if.RamWait}, 16'd0);
      check("rst_drv_rdc",  rd_count, 16'd0);
      reset = 1'b0;
      pins_idle();
      cyc(3);
      rd_chk("rd_after_rst", 23'h000012, 1'b0, 1'b0, 16'hA5C3);
      check("after_rst_rdc", rd_count, STATS ? 16'd1 : 16'd0);

      check("err_clear", {15'd0, protocol_err}, 16'd0);
      ram_if.MemAdr = 23'h000030;
      ram_if.RamCEn = 1'b0;
      ram_if.RamOEn = 1'b0;
      ram_if.RamWEn = 1'b0;
      cyc(3);
      check("err_oe_we", {15'd0, protocol_err}, 16'd1);
      pins_idle();
      cyc(4);
      check("err_sticky", {15'd0, protocol_err}, 16'd1);
      check("err_no_wr", wr_count, 16'd0);
      do_reset();
      check("err_rst", {15'd0, protocol_err}, 16'd0);
      ram_if.RamCRE = 1'b1;
      ram_if.RamCEn = 1'b0;
      ram_if.RamOEn = 1'b0;
      cyc(2);
      check("err_cre", {15'd0, protocol_err}, 16'd1);
      check("cre_no_wait", {15'd0, ram_if.RamWait}, 16'd0);
      pins_idle();
      cyc(3);
      check("cre_bus", mem_db, 16'hFFFF);
      check("cre_rdc", rd_count, 16'd0);

      do_reset();
      wr_word(23'h000000, 16'hBEEF, 1'b0, 1'b0, 12);
      rd_chk("rd_alias", 23'h000400, 1'b0, 1'b0, 16'hBEEF);
      check("alias_rdc", rd_count, STATS ? 16'd1 : 16'd0);
      check("alias_wrc", wr_count, STATS ? 16'd1 : 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
